frame_mem_arbiter: RTL and testbench

Arbitrates the single-port 256K x 8 frame memory between three requesters: the UART image loader (writes), the downsampling engine (reads/writes) and the UART data retriever (reads). A requester holds the memory for an entire burst (lock-until-release). Read data is returned with a one-cycle memory latency and tagged to the requester that issued the read. The block sits between the three clients and the memory primitive, and is the only driver of the memory port.

---
 rtl/frame_mem_arbiter_pkg.sv | 30 +++
 rtl/frame_mem_arbiter_if.sv | 35 +++
 rtl/frame_mem_arbiter_arb_pick.sv | 40 ++++
 rtl/frame_mem_arbiter.sv | 115 +++++++++++
 tb/tb_frame_mem_arbiter.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/frame_mem_arbiter_pkg.sv
// Shared definitions for the frame memory arbiter: bus widths, requester
// indices, FSM state encoding and small index helpers.
package frame_mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DATA_W = 8;

  localparam logic [1:0] REQ_LOADER    = 2'd0;
  localparam logic [1:0] REQ_DSP       = 2'd1;
  localparam logic [1:0] REQ_RETRIEVER = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    OWNED   = 2'b01,
    RELEASE = 2'b10
  } state_t;

  // One-hot grant vector to requester index (zero vector maps to loader).
  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    if (oh[1])      return REQ_DSP;
    else if (oh[2]) return REQ_RETRIEVER;
    else            return REQ_LOADER;
  endfunction

  // Next requester in the circular order 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == REQ_RETRIEVER) ? REQ_LOADER : idx + 2'd1;
  endfunction

endpackage

// File: rtl/frame_mem_arbiter_if.sv
// Client and memory-side signals of the frame memory arbiter.
// slave: arbiter view; master: clients plus memory primitive view.
interface frame_mem_arbiter_if;
  import frame_mem_arbiter_pkg::*;

  logic [2:0]        req;
  logic [2:0]        acc;
  logic [2:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [DATA_W-1:0] wdata2;
  logic [2:0]        gnt;
  logic [2:0]        rvalid;
  logic [DATA_W-1:0] rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  req, acc, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_rdata,
    output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output req, acc, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_rdata,
    input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/frame_mem_arbiter_arb_pick.sv
// Combinational winner selection returning a one-hot pick.
// ARB_ROUND_ROBIN_EN selects round-robin from rr_last; otherwise fixed
// priority loader > downsampler > retriever.
module arb_pick (
  input  logic [2:0] req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic [1:0] rr_last,
`endif
  output logic [2:0] pick
);
  import frame_mem_arbiter_pkg::*;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] cand;
  logic       found;

  // Search starts at the requester after the last owner and walks the ring.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = next_idx(rr_last);
    for (int unsigned k = 0; k < 3; k++) begin
      if (!found && req[cand]) begin
        pick[cand] = 1'b1;
        found      = 1'b1;
      end
      cand = next_idx(cand);
    end
  end
`else
  // Lowest index wins.
  always_comb begin
    pick = '0;
    if (req[REQ_LOADER])         pick[REQ_LOADER]    = 1'b1;
    else if (req[REQ_DSP])       pick[REQ_DSP]       = 1'b1;
    else if (req[REQ_RETRIEVER]) pick[REQ_RETRIEVER] = 1'b1;
  end
`endif

endmodule

// File: rtl/frame_mem_arbiter.sv
// Three-client arbiter for the single-port frame memory. A granted client
// holds the memory until it drops req, followed by a one-cycle turnaround.
// Optional macro: ARB_ROUND_ROBIN_EN (round-robin instead of fixed priority).
module frame_mem_arbiter (
  input logic               clk,
  input logic               rst_n,
  frame_mem_arbiter_if.slave bus
);
  import frame_mem_arbiter_pkg::*;

  state_t     state, state_nxt;
  logic [1:0] owner, owner_nxt;
  logic [2:0] gnt_q, gnt_nxt;
  logic [2:0] rvalid_q;
  logic [2:0] pick;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] rr_last;

  arb_pick u_pick (
    .req     (bus.req),
    .rr_last (rr_last),
    .pick    (pick)
  );

  // Remember the last winner; reset value makes the loader win first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         rr_last <= REQ_RETRIEVER;
    else if (state == IDLE && |bus.req) rr_last <= onehot_to_idx(pick);
  end
`else
  arb_pick u_pick (
    .req  (bus.req),
    .pick (pick)
  );
`endif

  // State, owner and grant registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= REQ_LOADER;
      gnt_q <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      gnt_q <= gnt_nxt;
    end
  end

  // Next-state: arbitrate in IDLE, hold while owner requests, one turnaround cycle.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    gnt_nxt   = gnt_q;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          state_nxt = OWNED;
          gnt_nxt   = pick;
          owner_nxt = onehot_to_idx(pick);
        end
      end
      OWNED: begin
        if (!bus.req[owner]) begin
          state_nxt = RELEASE;
          gnt_nxt   = '0;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // Memory port mux driven from the registered owner; idle outside OWNED.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (state == OWNED) begin
      bus.mem_en = bus.acc[owner];
      bus.mem_we = bus.acc[owner] & bus.we[owner];
      case (owner)
        REQ_DSP: begin
          bus.mem_addr  = bus.addr1;
          bus.mem_wdata = bus.wdata1;
        end
        REQ_RETRIEVER: begin
          bus.mem_addr  = bus.addr2;
          bus.mem_wdata = bus.wdata2;
        end
        default: begin
          bus.mem_addr  = bus.addr0;
          bus.mem_wdata = bus.wdata0;
        end
      endcase
    end
  end

  // Read-valid tag follows the memory's one-cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rvalid_q <= '0;
    else        rvalid_q <= gnt_q & bus.acc & ~bus.we;
  end

  assign bus.gnt    = gnt_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = bus.mem_rdata;
  assign bus.busy   = (state != IDLE);

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Directed bench for frame_mem_arbiter with a small behavioural memory.
module tb_frame_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  frame_mem_arbiter_if bus ();

  frame_mem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory model: unwritten locations read as addr[7:0] ^ 8'hA5.
  logic [7:0] mem_model [logic [17:0]];
  initial bus.mem_rdata = '0;
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) mem_model[bus.mem_addr] = bus.mem_wdata;
    else if (bus.mem_en && !bus.mem_we)
      bus.mem_rdata <= mem_model.exists(bus.mem_addr) ? mem_model[bus.mem_addr]
                                                      : (bus.mem_addr[7:0] ^ 8'hA5);
  end

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [17:0] a;
  int unsigned pulses;

  initial begin
    rst_n = 1'b0;
    bus.req = '0; bus.acc = '0; bus.we = '0;
    bus.addr0 = '0; bus.addr1 = '0; bus.addr2 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0; bus.wdata2 = '0;
    step();
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_rvalid", 32'(bus.rvalid), 0);
    check("rst_mem_en", 32'(bus.mem_en), 0);
    check("rst_mem_we", 32'(bus.mem_we), 0);
    check("rst_mem_addr", 32'(bus.mem_addr), 0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    check("rst_busy", 32'(bus.busy), 0);
    rst_n = 1'b1;
    step();

    // Single request from the retriever with one read.
    bus.req = 3'b100;
    step();
    check("t1_gnt", 32'(bus.gnt), 32'b100);
    check("t1_busy", 32'(bus.busy), 1);
    bus.acc = 3'b100; bus.we = 3'b000; bus.addr2 = 18'd5;
    #1;
    check("t1_mem_en", 32'(bus.mem_en), 1);
    check("t1_mem_we", 32'(bus.mem_we), 0);
    check("t1_mem_addr", 32'(bus.mem_addr), 5);
    step();
    check("t1_rvalid", 32'(bus.rvalid), 32'b100);
    check("t1_rdata", 32'(bus.rdata), 32'hA0);
    bus.acc = '0; bus.req = '0;
    step();
    check("t1_rel_gnt", 32'(bus.gnt), 0);
    check("t1_rel_rvalid", 32'(bus.rvalid), 0);
    check("t1_rel_busy", 32'(bus.busy), 1);
    check("t1_rel_mem_en", 32'(bus.mem_en), 0);
    step();
    check("t1_idle_busy", 32'(bus.busy), 0);

    // Simultaneous requests; loader wins, writes in its final owned cycle.
    bus.req = 3'b111;
    step();
    check("t2_gnt_loader", 32'(bus.gnt), 32'b001);
    bus.acc = 3'b001; bus.we = 3'b001; bus.addr0 = 18'h123; bus.wdata0 = 8'h5A;
    bus.req = 3'b110;
    #1;
    check("t2_mem_we", 32'(bus.mem_we), 1);
    check("t2_mem_addr", 32'(bus.mem_addr), 32'h123);
    check("t2_mem_wdata", 32'(bus.mem_wdata), 32'h5A);
    step();
    bus.acc = '0; bus.we = '0;
    check("t2_rel_gnt", 32'(bus.gnt), 0);
    check("t2_rel_busy", 32'(bus.busy), 1);
    step();
    check("t2_idle_gnt", 32'(bus.gnt), 0);
    check("t2_idle_busy", 32'(bus.busy), 0);
    step();
    check("t2_gnt_dsp", 32'(bus.gnt), 32'b010);

    // Non-owner strobes are ignored while the downsampler owns.
    bus.acc = 3'b101; bus.we = 3'b001;
    bus.addr0 = 18'd7; bus.addr1 = 18'h40; bus.addr2 = 18'd9; bus.wdata0 = 8'hEE;
    #1;
    check("t3_mem_en", 32'(bus.mem_en), 0);
    check("t3_mem_we", 32'(bus.mem_we), 0);
    check("t3_mem_addr", 32'(bus.mem_addr), 32'h40);
    step();

    // Read in the last owned cycle; loader re-requests alongside retriever.
    bus.acc = 3'b010; bus.we = 3'b000; bus.addr1 = 18'h123; bus.req = 3'b101;
    #1;
    check("t4_mem_en", 32'(bus.mem_en), 1);
    check("t4_mem_addr", 32'(bus.mem_addr), 32'h123);
    step();
    bus.acc = '0;
    check("t4_rel_gnt", 32'(bus.gnt), 0);
    check("t4_rel_rvalid", 32'(bus.rvalid), 32'b010);
    check("t4_rel_rdata", 32'(bus.rdata), 32'h5A);
    check("t4_rel_busy", 32'(bus.busy), 1);
    step();
    check("t4_idle_rvalid", 32'(bus.rvalid), 0);
    step();
`ifdef ARB_ROUND_ROBIN_EN
    check("t4_next_gnt", 32'(bus.gnt), 32'b100);
`else
    check("t4_next_gnt", 32'(bus.gnt), 32'b001);
`endif
    bus.req = '0;
    step();
    step();

    // Retriever burst across the top of the address space, others waiting.
    bus.req = 3'b100;
    step();
    check("t5_gnt", 32'(bus.gnt), 32'b100);
    bus.req = 3'b111;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      a = 18'(262128 + i);
      bus.addr2 = a; bus.acc = 3'b100; bus.we = 3'b000;
      #1;
      check("t5_mem_addr", 32'(bus.mem_addr), 32'(a));
      step();
      check("t5_gnt_hold", 32'(bus.gnt), 32'b100);
      check("t5_rvalid", 32'(bus.rvalid), 32'b100);
      check("t5_rdata", 32'(bus.rdata), 32'(a[7:0] ^ 8'hA5));
      if (bus.rvalid == 3'b100) pulses++;
    end
    bus.acc = '0; bus.req = 3'b011;
    step();
    check("t5_rel_gnt", 32'(bus.gnt), 0);
    check("t5_rel_rvalid", 32'(bus.rvalid), 0);
    check("t5_pulses", pulses, 16);
    step();
    step();
    check("t5_next_gnt", 32'(bus.gnt), 32'b001);

    // Reset mid-burst with a read pending and a write on the port.
    bus.acc = 3'b001; bus.we = 3'b000; bus.addr0 = 18'h10;
    step();
    check("t6_rvalid", 32'(bus.rvalid), 32'b001);
    bus.we = 3'b001; bus.wdata0 = 8'h77;
    #1;
    check("t6_mem_we", 32'(bus.mem_we), 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_gnt", 32'(bus.gnt), 0);
    check("t6_rst_mem_en", 32'(bus.mem_en), 0);
    check("t6_rst_mem_we", 32'(bus.mem_we), 0);
    check("t6_rst_rvalid", 32'(bus.rvalid), 0);
    check("t6_rst_busy", 32'(bus.busy), 0);
    check("t6_rst_mem_addr", 32'(bus.mem_addr), 0);
    bus.acc = '0; bus.we = '0; bus.req = 3'b011;
    step();
    step();
    rst_n = 1'b1;
    step();
    check("t6_post_gnt", 32'(bus.gnt), 32'b001);
    bus.req = '0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
